// File: rtl/tdc_multichannel_core.sv
// Multi-channel TDC core: shared start, per-channel stop capture, buffered readout.
// Optional TDC_BUBBLE_FIX_EN enables a majority bubble filter on the fine code.
module tdc_multichannel_core #(
  parameter  int TAPS     = 16,
  parameter  int COARSE_W = 8,
  parameter  int CHANNELS = 2,
  localparam int FINE_W   = $clog2(TAPS) + 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm_i,
  input  logic                     start_i,
  input  logic [CHANNELS-1:0]      stop_i,
  input  logic [CHANNELS*TAPS-1:0] taps_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [CH_W-1:0]          res_chan_o,
  output logic [COARSE_W-1:0]      res_coarse_o,
  output logic [FINE_W-1:0]        res_fine_o,
  output logic                     res_timeout_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic                               start_q;
  logic [CHANNELS-1:0]                stop_q;
  logic                               start_edge;
  logic [CHANNELS-1:0]                stop_edge;
  logic [COARSE_W-1:0]                coarse;
  logic                               sat;
  logic                               run_st;
  logic [CHANNELS-1:0]                hit;
  logic [CHANNELS-1:0]                hit_nx;
  logic [CHANNELS-1:0]                cap;
  logic [CHANNELS-1:0]                tmo;
  logic [CHANNELS-1:0][COARSE_W-1:0]  res_coarse;
  logic [CHANNELS-1:0][FINE_W-1:0]    res_fine;
  logic [CHANNELS-1:0][FINE_W-1:0]    fine_now;
  logic [CHANNELS-1:0]                res_to;
  logic [CH_W-1:0]                    rd_idx;
  logic                               last_rd;

  function automatic logic [FINE_W-1:0] fine_code(
    input logic [TAPS-1:0] t
  );
`ifdef TDC_BUBBLE_FIX_EN
    logic [TAPS+1:0]   ext;
    logic [TAPS-1:0]   f;
    logic              run;
    logic [FINE_W-1:0] n;
    // ext[i+1] is tap i; edges padded 1 below and 0 above
    ext = {1'b0, t, 1'b1};
    f   = '0;
    for (int i = 0; i < TAPS; i++) begin
      f[i] = (ext[i] & ext[i+1]) |
             (ext[i] & ext[i+2]) |
             (ext[i+1] & ext[i+2]);
    end
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      run = run & f[i];
      n   = n + FINE_W'(run);
    end
    return n;
`else
    logic [FINE_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) begin
      n = n + FINE_W'(t[i]);
    end
    return n;
`endif
  endfunction

  always_comb begin
    fine_now = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fine_now[c] = fine_code(taps_i[c*TAPS +: TAPS]);
    end
  end

  assign start_edge = start_i & ~start_q;
  assign stop_edge  = stop_i & ~stop_q;
  assign sat        = &coarse;
  assign run_st     = (state == RUN);
  assign cap        = run_st ? (stop_edge & ~hit) : '0;
  // a stop edge in the saturation cycle wins over timeout
  assign tmo        = (run_st && sat) ? (~hit & ~stop_edge) : '0;
  assign hit_nx     = hit | cap | tmo;
  assign last_rd    = (rd_idx == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (arm_i) state_nx = ARMED;
      end
      ARMED: begin
        if (start_edge) state_nx = RUN;
      end
      RUN: begin
        if (&hit_nx) state_nx = DRAIN;
      end
      DRAIN: begin
        if (res_ready_i && last_rd) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= '0;
    end else begin
      start_q <= start_i;
      stop_q  <= stop_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse     <= '0;
      hit        <= '0;
      res_coarse <= '0;
      res_fine   <= '0;
      res_to     <= '0;
      rd_idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          coarse     <= '0;
          hit        <= '0;
          res_coarse <= '0;
          res_fine   <= '0;
          res_to     <= '0;
          rd_idx     <= '0;
        end
        ARMED: begin
          if (start_edge) coarse <= '0;
        end
        RUN: begin
          if (!sat) coarse <= coarse + COARSE_W'(1);
          hit <= hit_nx;
          for (int c = 0; c < CHANNELS; c++) begin
            if (cap[c]) begin
              res_coarse[c] <= coarse;
              res_fine[c]   <= fine_now[c];
            end else if (tmo[c]) begin
              res_coarse[c] <= '1;
              res_fine[c]   <= '0;
              res_to[c]     <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (res_ready_i && !last_rd) begin
            rd_idx <= rd_idx + CH_W'(1);
          end
        end
        default: begin
          coarse <= '0;
        end
      endcase
    end
  end

  assign res_valid_o   = (state == DRAIN);
  assign busy_o        = (state != IDLE);
  assign res_chan_o    = res_valid_o ? rd_idx : '0;
  assign res_coarse_o  = res_valid_o ? res_coarse[rd_idx] : '0;
  assign res_fine_o    = res_valid_o ? res_fine[rd_idx] : '0;
  assign res_timeout_o = res_valid_o ? res_to[rd_idx] : 1'b0;

endmodule

// File: tb/tb_tdc_multichannel_core.sv
// Directed bench for tdc_multichannel_core (2 channels, 16 taps, 8-bit coarse).
// Bubble expectation follows TDC_BUBBLE_FIX_EN.
module tb_tdc_multichannel_core;

`ifdef TDC_BUBBLE_FIX_EN
  localparam int BUB_FINE = 6;
`else
  localparam int BUB_FINE = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i;
  logic        start_i;
  logic [1:0]  stop_i;
  logic [31:0] taps_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        res_chan_o;
  logic [7:0]  res_coarse_o;
  logic [4:0]  res_fine_o;
  logic        res_timeout_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int rel    = 0;

  tdc_multichannel_core #(
    .TAPS(16),
    .COARSE_W(8),
    .CHANNELS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm_i(arm_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .taps_i(taps_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_chan_o(res_chan_o),
    .res_coarse_o(res_coarse_o),
    .res_fine_o(res_fine_o),
    .res_timeout_o(res_timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input string tag, input bit to,
                            input int ch, input int co, input int fi);
    logic [31:0] e;
    e = {12'd0, 1'b1, to, 1'b0, 1'(ch), 8'(co), 3'd0, 5'(fi)};
    check(tag, {12'd0, res_valid_o, res_timeout_o, 1'b0, res_chan_o,
                res_coarse_o, 3'd0, res_fine_o}, e);
  endtask

  task automatic all_zero(input string tag);
    check(tag, {15'd0, busy_o, res_valid_o, res_timeout_o, res_chan_o,
                res_coarse_o, res_fine_o}, 32'd0);
  endtask

  task automatic idle_levels();
    arm_i       = 1'b0;
    start_i     = 1'b0;
    stop_i      = 2'b00;
    taps_i      = '0;
    res_ready_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic arm_and_start();
    arm_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    start_i = 1'b1;
    tick();
    rel = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    arm_i       = 1'b0;
    start_i     = 1'b0;
    stop_i      = 2'b00;
    taps_i      = '0;
    res_ready_i = 1'b0;
    tick();
    tick();
    all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy_o), 32'd0);

    // basic measurement
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    check("armed_busy", 32'(busy_o), 32'd1);
    start_i = 1'b1;
    tick();
    repeat (4) tick();
    stop_i[0]     = 1'b1;
    taps_i[15:0]  = 16'h003F;
    tick();
    check("run_no_valid", 32'(res_valid_o), 32'd0);
    repeat (3) tick();
    stop_i[1]     = 1'b1;
    taps_i[31:16] = 16'h0FFF;
    tick();
    expect_res("basic_ch0", 1'b0, 0, 4, 6);
    res_ready_i = 1'b1;
    tick();
    expect_res("basic_ch1", 1'b0, 1, 8, 12);
    tick();
    check("basic_done", {30'd0, busy_o, res_valid_o}, 32'd0);
    idle_levels();

    // timeout on ch1
    arm_and_start();
    repeat (2) tick();
    stop_i[0]    = 1'b1;
    taps_i[15:0] = 16'h0001;
    tick();
    rel = 3;
    for (int i = 0; i < 300 && !res_valid_o; i++) begin
      tick();
      rel++;
    end
    check("tmo_entry", 32'(rel), 32'd256);
    expect_res("tmo_ch0", 1'b0, 0, 2, 1);
    res_ready_i = 1'b1;
    tick();
    expect_res("tmo_ch1", 1'b1, 1, 255, 0);
    tick();
    check("tmo_done", {30'd0, busy_o, res_valid_o}, 32'd0);
    idle_levels();

    // simultaneous stops, backpressure, bubble on ch0
    arm_and_start();
    tick();
    stop_i = 2'b11;
    taps_i = {16'h00FF, 16'h043F};
    tick();
    for (int i = 0; i < 10; i++) begin
      expect_res("bp_hold", 1'b0, 0, 1, BUB_FINE);
      tick();
    end
    res_ready_i = 1'b1;
    tick();
    expect_res("bp_ch1", 1'b0, 1, 1, 8);
    tick();
    check("bp_done", {30'd0, busy_o, res_valid_o}, 32'd0);
    idle_levels();

    // edge filtering
    stop_i[1] = 1'b1;
    tick();
    arm_i = 1'b1;
    tick();
    arm_i     = 1'b0;
    start_i   = 1'b1;
    stop_i[0] = 1'b1;
    tick();
    stop_i[0] = 1'b0;
    tick();
    stop_i[0]    = 1'b1;
    taps_i[15:0] = 16'h0003;
    tick();
    stop_i[0] = 1'b0;
    tick();
    stop_i[0]    = 1'b1;
    taps_i[15:0] = 16'hFFFF;
    tick();
    stop_i[1] = 1'b0;
    tick();
    check("ef_wait", {30'd0, busy_o, res_valid_o}, 32'd2);
    stop_i[1]     = 1'b1;
    taps_i[31:16] = 16'h001F;
    tick();
    expect_res("ef_ch0", 1'b0, 0, 1, 2);
    res_ready_i = 1'b1;
    tick();
    expect_res("ef_ch1", 1'b0, 1, 5, 5);
    tick();
    check("ef_done", {30'd0, busy_o, res_valid_o}, 32'd0);
    idle_levels();

    // reset mid-RUN, then minimum-latency measurement
    arm_and_start();
    stop_i[0]    = 1'b1;
    taps_i[15:0] = 16'h00FF;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    all_zero("rst_mid_run");
    rst_n   = 1'b1;
    start_i = 1'b0;
    stop_i  = 2'b00;
    taps_i  = '0;
    tick();
    arm_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    start_i = 1'b1;
    tick();
    stop_i = 2'b11;
    taps_i = {16'h0007, 16'h0001};
    tick();
    expect_res("min_ch0", 1'b0, 0, 0, 1);
    res_ready_i = 1'b1;
    tick();
    expect_res("min_ch1", 1'b0, 1, 0, 3);
    check("min_busy_last", 32'(busy_o), 32'd1);
    tick();
    check("min_idle", {30'd0, busy_o, res_valid_o}, 32'd0);
    idle_levels();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_multichannel_core.md
# tdc_multichannel_core

Synchronous measurement core for a multi-channel time-to-digital converter. A shared start event launches a coarse cycle counter. Each channel's stop event captures that counter together with a fine code taken from the channel's delay-line tap snapshot. Results drain one per valid/ready handshake and feed the top-level output mux. This is the parametrised successor of the single inverter-chain TDC: N channels, configurable tap count and coarse range, timeout detection, and buffered readout.

## Interface
- TAPS, 16, delay-line taps per channel; power of two, 4..64
- COARSE_W, 8, coarse counter width
- CHANNELS, 2, stop channels, 1..4
- Derived widths: FINE_W = $clog2(TAPS)+1; CH_W = max(1, $clog2(CHANNELS))

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- arm_i  in  1  one-cycle arm request
- start_i  in  1  start level, already synchronised to clk
- stop_i  in  CHANNELS  per-channel stop levels, already synchronised
- taps_i  in  CHANNELS*TAPS  clk-sampled thermometer snapshots; channel c is [c*TAPS +: TAPS]; bit 0 is the earliest tap
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_chan_o  out  CH_W  channel index of the result
- res_coarse_o  out  COARSE_W  coarse count
- res_fine_o  out  FINE_W  fine code
- res_timeout_o  out  1  channel never stopped
- busy_o  out  1  high in every state except IDLE

## Operation
- Edge detection: start_q and stop_q[] are registered every cycle in all states. An edge is level=1 with previous=0.
- FSM states are IDLE, ARMED, RUN and DRAIN. The reset state is IDLE.
- IDLE:
  - arm_i=1 moves to ARMED.
  - Clears all per-channel hit flags and result registers.
- ARMED:
  - A start edge moves to RUN and sets coarse to 0.
  - arm_i and stop edges are ignored.
- RUN:
  - coarse increments by 1 each cycle and saturates at 2^COARSE_W-1.
  - A stop edge on channel c with hit[c]=0 stores coarse, stores fine (computed from taps_i in the same cycle), and sets hit[c].
  - Later stop edges on an already-hit channel are ignored.
  - Simultaneous stop edges on several channels are all captured in that cycle.
  - Moves to DRAIN when all hit flags are set.
- Timeout:
  - Triggers in RUN when coarse equals 2^COARSE_W-1 and a stop edge is absent on at least one unhit channel.
  - Each such channel stores coarse=all-ones, fine=0 and timeout=1.
  - The FSM then moves to DRAIN.
  - A stop edge in the saturation cycle is captured normally (stop wins).
- DRAIN:
  - Presents results in ascending channel order, 0..CHANNELS-1.
  - A result is held stable while res_valid_o=1 and res_ready_i=0.
  - Each handshake (valid&ready) advances to the next channel.
  - The final handshake returns to IDLE.
- Fine code without the macro: popcount of the channel's TAPS bits, range 0..TAPS.
- Reset mid-operation: any state returns to IDLE on the next edge. A pending result is discarded.

## Timing
- Reset values: every output is 0, and every internal register is 0.
- T0 is the cycle in which ARMED sees the start edge.
  - A stop edge seen at T0+k (k ≥ 1) records coarse = k-1.
  - A stop edge at T0 itself is ignored.
  - Coarse resolution is one clk period. Fine resolution is one tap delay.
- Stop capture to DRAIN entry: 1 cycle after the last hit.
- res_valid_o rises in the first DRAIN cycle and stays high until the final handshake.
- Back-to-back readout: one result per cycle when res_ready_i is held at 1.
- busy_o falls in the cycle after the final handshake.
- Minimum cycle count per measurement with CHANNELS=2, stops at T0+1, and ready held at 1: 5 cycles from arm to IDLE.

## Configuration
- Macro TDC_BUBBLE_FIX_EN.
- Defined:
  - Each tap is replaced by the 3-input majority of taps i-1, i and i+1.
  - The out-of-range neighbour is 1 below bit 0 and 0 above bit TAPS-1.
  - fine = number of consecutive ones from bit 0 of the filtered vector (index of the first zero, or TAPS if all ones).
- Undefined: fine = raw popcount; no filter logic is instantiated.
- Coarse logic, FSM behaviour and timing are identical in both builds.

## Test plan
- Basic measurement (CHANNELS=2, TAPS=16, COARSE_W=8):
  - Stimulus: arm, start edge at T0; ch0 stop at T0+5 with taps 16'h003F; ch1 stop at T0+9 with taps 16'h0FFF.
  - Required response: results (ch0, coarse 4, fine 6) then (ch1, coarse 8, fine 12), timeout=0.
- Timeout:
  - Stimulus: ch0 stops at T0+3; ch1 never stops.
  - Required response: ch0 coarse 2; ch1 coarse 255, fine 0, timeout=1. DRAIN is entered at T0+256.
- Backpressure and ordering:
  - Stimulus: both channels stop in the same cycle T0+2; res_ready_i is held low for 10 cycles.
  - Required response: ch0 result is held stable for those 10 cycles, then ch1 follows; both show coarse 1.
- Edge filtering:
  - Stimulus: stop held high before start; second ch0 edge during RUN; stop edge in the same cycle as start.
  - Required response: only the first post-T0 edge on each channel is recorded.
- Bubble handling:
  - Stimulus: taps 16'b0000_0100_0011_1111.
  - Required response: fine=7 without TDC_BUBBLE_FIX_EN; fine=6 with it.
- Reset mid-RUN:
  - Stimulus: rst_n low for one cycle during RUN.
  - Required response: all outputs 0 and busy_o=0 on the next edge; a fresh arm/start/stop sequence then measures correctly.
